// File: rtl/uart_mem_bridge_pkg.sv
// Shared types and constants for the UART-to-memory-bus debug bridge.
package uart_mem_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_MEM  = 3'd3,
        ST_RESP = 3'd4
    } state_t;

    localparam logic [7:0] CMD_W = 8'h57;
    localparam logic [7:0] CMD_R = 8'h52;
    localparam logic [7:0] CMD_H = 8'h48;
    localparam logic [7:0] CMD_G = 8'h47;

    localparam logic [7:0] ACK_DEFAULT = 8'h06;
    localparam logic [7:0] NAK_DEFAULT = 8'h15;

    localparam int TIMEOUT_DEFAULT = 10_000_000;

endpackage

// File: rtl/bridge_timeout_counter.sv
// Free-running timeout counter: clear has priority, counts while enabled and
// pulses expired for one cycle when it reaches TERMINAL-1 (then restarts at 0).
module bridge_timeout_counter #(
    parameter int TERMINAL = 10_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TERMINAL > 1) ? $clog2(TERMINAL) : 1;
    localparam logic [CW-1:0] LAST = CW'(TERMINAL - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count and terminal-count pulse.
    always_comb begin
        expired = 1'b0;
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            if (count_q == LAST) begin
                expired = 1'b1;
                count_d = '0;
            end else begin
                count_d = count_q + CW'(1);
            end
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_mem_bridge.sv
// Host-driven bus initiator: decodes UART command bytes, issues one 32-bit
// memory transaction per command and returns the reply through the UART TX.
module uart_mem_bridge
    import uart_mem_bridge_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter logic [7:0] ACK_BYTE       = ACK_DEFAULT,
    parameter logic [7:0] NAK_BYTE       = NAK_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_ready,
    output logic        rx_read,
    output logic [7:0]  tx_data,
    output logic        tx_write,
    input  logic        tx_ready,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        hold,
    output logic        busy
);

    state_t      state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [23:0] addr_sr_q, addr_sr_d;   // first three address bytes
    logic [23:0] data_sr_q, data_sr_d;   // first three data bytes
    logic        is_write_q, is_write_d;
    logic        mem_valid_q, mem_valid_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        hold_q, hold_d;
    logic [31:0] resp_sr_q, resp_sr_d;   // reply bytes, next one in [31:24]
    logic [1:0]  resp_left_q, resp_left_d;
    logic        rx_read_q, rx_read_d;
    logic        rx_guard_q, rx_guard_d;
    logic        tx_write_q, tx_write_d;
    logic        tx_guard_q, tx_guard_d;
    logic [7:0]  tx_data_q, tx_data_d;

    logic in_rx_state;
    logic in_cmd_body;
    logic take;
    logic timeout_expired;

    // A byte is accepted only in a receive state, never during the rx_read
    // pulse itself nor on the guard cycle while the receiver drops rx_ready.
    assign in_cmd_body = (state_q == ST_ADDR) || (state_q == ST_DATA);
    assign in_rx_state = (state_q == ST_IDLE) || in_cmd_body;
    assign take        = in_rx_state && rx_ready && !rx_read_q && !rx_guard_q;

    bridge_timeout_counter #(
        .TERMINAL (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (take || !in_cmd_body),
        .enable  (in_cmd_body),
        .expired (timeout_expired)
    );

    // Command FSM: next state, shift registers and bus/UART handshakes.
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        addr_sr_d   = addr_sr_q;
        data_sr_d   = data_sr_q;
        is_write_d  = is_write_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        hold_d      = hold_q;
        resp_sr_d   = resp_sr_q;
        resp_left_d = resp_left_q;
        rx_read_d   = take;
        rx_guard_d  = rx_read_q;
        tx_write_d  = 1'b0;
        tx_guard_d  = tx_write_q;
        tx_data_d   = tx_data_q;

        case (state_q)
            ST_IDLE: begin
                if (take) begin
                    resp_sr_d   = {ACK_BYTE, 24'h0};
                    resp_left_d = 2'd0;
                    case (rx_data)
                        CMD_W: begin
                            is_write_d = 1'b1;
                            state_d    = ST_ADDR;
                        end
                        CMD_R: begin
                            is_write_d = 1'b0;
                            state_d    = ST_ADDR;
                        end
                        CMD_H: begin
                            hold_d  = 1'b1;
                            state_d = ST_RESP;
                        end
                        CMD_G: begin
                            hold_d  = 1'b0;
                            state_d = ST_RESP;
                        end
                        default: begin
                            resp_sr_d = {NAK_BYTE, 24'h0};
                            state_d   = ST_RESP;
                        end
                    endcase
                end
            end
            ST_ADDR: begin
                if (take) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    addr_sr_d  = {addr_sr_q[15:0], rx_data};
                    if (byte_cnt_q == 2'd3) begin
                        mem_addr_d = {addr_sr_q, rx_data[7:2], 2'b00};
                        if (is_write_q) begin
                            state_d = ST_DATA;
                        end else begin
                            state_d     = ST_MEM;
                            mem_valid_d = 1'b1;
                        end
                    end
                end else if (timeout_expired) begin
                    state_d    = ST_IDLE;
                    byte_cnt_d = 2'd0;
                end
            end
            ST_DATA: begin
                if (take) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    data_sr_d  = {data_sr_q[15:0], rx_data};
                    if (byte_cnt_q == 2'd3) begin
                        mem_wdata_d = {data_sr_q, rx_data};
                        state_d     = ST_MEM;
                        mem_valid_d = 1'b1;
                    end
                end else if (timeout_expired) begin
                    state_d    = ST_IDLE;
                    byte_cnt_d = 2'd0;
                end
            end
            ST_MEM: begin
                if (mem_ready) begin
                    mem_valid_d = 1'b0;
                    state_d     = ST_RESP;
                    if (is_write_q) begin
                        resp_sr_d   = {ACK_BYTE, 24'h0};
                        resp_left_d = 2'd0;
                    end else begin
                        resp_sr_d   = mem_rdata;
                        resp_left_d = 2'd3;
                    end
                end
            end
            ST_RESP: begin
                if (tx_ready && !tx_write_q && !tx_guard_q) begin
                    tx_write_d  = 1'b1;
                    tx_data_d   = resp_sr_q[31:24];
                    resp_sr_d   = {resp_sr_q[23:0], 8'h00};
                    resp_left_d = resp_left_q - 2'd1;
                    if (resp_left_q == 2'd0) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            byte_cnt_q  <= 2'd0;
            addr_sr_q   <= 24'h0;
            data_sr_q   <= 24'h0;
            is_write_q  <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            hold_q      <= 1'b0;
            resp_sr_q   <= 32'h0;
            resp_left_q <= 2'd0;
            rx_read_q   <= 1'b0;
            rx_guard_q  <= 1'b0;
            tx_write_q  <= 1'b0;
            tx_guard_q  <= 1'b0;
            tx_data_q   <= 8'h0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            addr_sr_q   <= addr_sr_d;
            data_sr_q   <= data_sr_d;
            is_write_q  <= is_write_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            hold_q      <= hold_d;
            resp_sr_q   <= resp_sr_d;
            resp_left_q <= resp_left_d;
            rx_read_q   <= rx_read_d;
            rx_guard_q  <= rx_guard_d;
            tx_write_q  <= tx_write_d;
            tx_guard_q  <= tx_guard_d;
            tx_data_q   <= tx_data_d;
        end
    end

    assign rx_read   = rx_read_q;
    assign tx_data   = tx_data_q;
    assign tx_write  = tx_write_q;
    assign mem_valid = mem_valid_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = (mem_valid_q && is_write_q) ? 4'hF : 4'h0;
    assign hold      = hold_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Randomized self-checking bench for uart_mem_bridge: UART RX/TX and memory
// bus models plus a command-level reference model of replies and transactions.
module tb_uart_mem_bridge;

    localparam int TO = 300;
    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        rx_read;
    logic [7:0]  tx_data;
    logic        tx_write;
    logic        tx_ready;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        hold;
    logic        busy;

    always #5 clk = ~clk;

    uart_mem_bridge #(.TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .rx_read   (rx_read),
        .tx_data   (tx_data),
        .tx_write  (tx_write),
        .tx_ready  (tx_ready),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .hold      (hold),
        .busy      (busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- UART receiver model ----------------
    logic [7:0] rx_q[$];
    int rx_gap   = 0;
    int rx_taken = 0;

    initial begin
        rx_ready = 1'b0;
        rx_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (rx_read) check("rx_read_needs_ready", rx_ready, 1);
            if (rx_ready && rx_read) begin
                rx_ready = 1'b0;
                rx_taken++;
                rx_gap = $urandom_range(0, 3);
            end else if (!rx_ready) begin
                if (rx_gap > 0) rx_gap--;
                else if (rx_q.size() > 0) begin
                    rx_data  = rx_q.pop_front();
                    rx_ready = 1'b1;
                end
            end
        end
    end

    // ---------------- UART transmitter model ----------------
    int tx_stall = 3;
    int tx_cnt   = 0;
    logic [7:0] tx_got[$];

    initial begin
        tx_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (tx_write) begin
                check("tx_write_needs_ready", tx_ready, 1);
                tx_got.push_back(tx_data);
                tx_ready = 1'b0;
                tx_cnt   = tx_stall;
                $display("tx byte %h", tx_data);
            end else if (!tx_ready) begin
                if (tx_cnt > 0) tx_cnt--;
                if (tx_cnt == 0) tx_ready = 1'b1;
            end
        end
    end

    // ---------------- Memory bus model ----------------
    logic [31:0] bus_mem [logic [31:0]];
    int mem_delay = 0;
    int mem_wait  = 0;
    bit in_txn    = 0;
    logic [31:0] c_addr, c_wdata;
    logic [3:0]  c_wstrb;
    logic [31:0] got_addr[$];
    logic [31:0] got_wdata[$];
    logic [3:0]  got_wstrb[$];

    function automatic logic [31:0] mem_default(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    initial begin
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (mem_ready) begin
                mem_ready = 1'b0;
                mem_rdata = $urandom;
                check("valid_drops_after_ready", mem_valid, 0);
                in_txn = 0;
            end else if (mem_valid) begin
                if (!in_txn) begin
                    in_txn   = 1;
                    mem_wait = 0;
                    c_addr   = mem_addr;
                    c_wdata  = mem_wdata;
                    c_wstrb  = mem_wstrb;
                    check("valid_only_when_busy", busy, 1);
                end else begin
                    check("addr_stable", mem_addr, c_addr);
                    check("wdata_stable", mem_wdata, c_wdata);
                    check("wstrb_stable", mem_wstrb, c_wstrb);
                    mem_wait++;
                end
                if (mem_wait >= mem_delay) begin
                    mem_ready = 1'b1;
                    if (mem_wstrb == 4'hF) bus_mem[mem_addr] = mem_wdata;
                    mem_rdata = bus_mem.exists(mem_addr) ? bus_mem[mem_addr] : mem_default(mem_addr);
                    got_addr.push_back(mem_addr);
                    got_wdata.push_back(mem_wdata);
                    got_wstrb.push_back(mem_wstrb);
                    $display("bus txn addr=%h wdata=%h wstrb=%h rdata=%h", mem_addr, mem_wdata, mem_wstrb, mem_rdata);
                end else begin
                    mem_rdata = $urandom;
                end
            end else begin
                in_txn = 0;
            end
        end
    end

    // ---------------- Command-level reference model ----------------
    logic [31:0] ref_mem [logic [31:0]];
    logic        ref_hold = 1'b0;
    logic [7:0]  exp_tx[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_wdata[$];
    logic [3:0]  exp_wstrb[$];
    bit          exp_wr[$];

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : mem_default(a);
    endfunction

    task automatic queue_cmd(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] a;
        logic [31:0] v;
        a = {addr[31:2], 2'b00};
        rx_q.push_back(cmd);
        if (cmd == 8'h57 || cmd == 8'h52)
            for (int i = 3; i >= 0; i--) rx_q.push_back(addr[i*8 +: 8]);
        if (cmd == 8'h57)
            for (int i = 3; i >= 0; i--) rx_q.push_back(data[i*8 +: 8]);
        case (cmd)
            8'h57: begin
                ref_mem[a] = data;
                exp_tx.push_back(ACK);
                exp_addr.push_back(a); exp_wdata.push_back(data);
                exp_wstrb.push_back(4'hF); exp_wr.push_back(1);
            end
            8'h52: begin
                v = ref_rd(a);
                for (int i = 3; i >= 0; i--) exp_tx.push_back(v[i*8 +: 8]);
                exp_addr.push_back(a); exp_wdata.push_back(32'h0);
                exp_wstrb.push_back(4'h0); exp_wr.push_back(0);
            end
            8'h48: begin ref_hold = 1'b1; exp_tx.push_back(ACK); end
            8'h47: begin ref_hold = 1'b0; exp_tx.push_back(ACK); end
            default: exp_tx.push_back(NAK);
        endcase
        $display("cmd %h addr=%h data=%h", cmd, addr, data);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 8000 && tx_got.size() < exp_tx.size(); i++) @(negedge clk);
        repeat (30) @(negedge clk);
        check({tag, "_rsp_count"}, tx_got.size(), exp_tx.size());
        for (int i = 0; i < exp_tx.size() && i < tx_got.size(); i++)
            check({tag, "_rsp_byte"}, tx_got[i], exp_tx[i]);
        check({tag, "_txn_count"}, got_addr.size(), exp_addr.size());
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            check({tag, "_txn_addr"}, got_addr[i], exp_addr[i]);
            check({tag, "_txn_wstrb"}, got_wstrb[i], exp_wstrb[i]);
            if (exp_wr[i]) check({tag, "_txn_wdata"}, got_wdata[i], exp_wdata[i]);
        end
        check({tag, "_rx_all_taken"}, rx_q.size() + int'(rx_ready), 0);
        check({tag, "_busy_idle"}, busy, 0);
        check({tag, "_hold"}, hold, ref_hold);
        check({tag, "_valid_idle"}, mem_valid, 0);
        rx_q.delete(); tx_got.delete(); exp_tx.delete();
        exp_addr.delete(); exp_wdata.delete(); exp_wstrb.delete(); exp_wr.delete();
        got_addr.delete(); got_wdata.delete(); got_wstrb.delete();
    endtask

    function automatic logic [7:0] rand_cmd();
        int r;
        logic [7:0] c;
        r = $urandom_range(0, 9);
        if (r <= 3) return 8'h57;
        if (r <= 6) return 8'h52;
        if (r == 7) return 8'h48;
        if (r == 8) return 8'h47;
        c = 8'($urandom);
        while (c == 8'h57 || c == 8'h52 || c == 8'h48 || c == 8'h47) c = 8'($urandom);
        return c;
    endfunction

    // ---------------- Main sequence ----------------
    initial begin
        int t0;
        bit seen;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_rx_read", rx_read, 0);
        check("rst_tx_write", tx_write, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_mem_valid", mem_valid, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_wstrb", mem_wstrb, 0);
        check("rst_busy", busy, 0);
        check("rst_hold", hold, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        queue_cmd(8'h57, 32'h8000_0014, 32'h0012_3456);
        drain("write");

        ref_mem[32'h100] = 32'hDEAD_BEEF;
        bus_mem[32'h100] = 32'hDEAD_BEEF;
        queue_cmd(8'h52, 32'h0000_0100, 32'h0);
        drain("read");

        // Partial read command abandoned by the inter-byte timeout.
        t0 = rx_taken;
        rx_q.push_back(8'h52); rx_q.push_back(8'h00); rx_q.push_back(8'h00);
        for (int i = 0; i < 200 && rx_taken < t0 + 3; i++) @(negedge clk);
        check("to_bytes_taken", rx_taken - t0, 3);
        repeat (TO / 2) @(negedge clk);
        check("to_busy_before_expiry", busy, 1);
        repeat (TO) @(negedge clk);
        check("to_busy_after_expiry", busy, 0);
        check("to_no_reply", tx_got.size(), 0);
        check("to_no_txn", got_addr.size(), 0);
        queue_cmd(8'h52, 32'h0000_0100, 32'h0);
        drain("after_timeout");

        queue_cmd(8'h5A, 32'h0, 32'h0);
        drain("unknown");
        queue_cmd(8'h48, 32'h0, 32'h0);
        drain("hold_set");
        queue_cmd(8'h47, 32'h0, 32'h0);
        drain("hold_clr");

        // Slow bus and slow transmitter, commands queued back to back.
        mem_delay = 7;
        tx_stall  = 50;
        queue_cmd(8'h57, 32'h0000_2003, 32'hCAFE_F00D);
        queue_cmd(8'h52, 32'h0000_2001, 32'h0);
        queue_cmd(8'h52, 32'h0000_0100, 32'h0);
        drain("stall");

        for (int it = 0; it < 25; it++) begin
            mem_delay = $urandom_range(0, 8);
            tx_stall  = $urandom_range(0, 6);
            for (int n = 0; n < int'($urandom_range(1, 3)); n++)
                queue_cmd(rand_cmd(), 32'h1000_0000 | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3), $urandom);
            drain("rand");
        end

        // Reset while a read is stuck on the bus.
        mem_delay = 0;
        tx_stall  = 3;
        queue_cmd(8'h48, 32'h0, 32'h0);
        drain("pre_reset_hold");
        mem_delay = 100000;
        rx_q.push_back(8'h52);
        for (int i = 3; i >= 0; i--) rx_q.push_back(8'(i));
        seen = 0;
        for (int i = 0; i < 500 && !seen; i++) begin
            @(negedge clk);
            if (mem_valid) seen = 1;
        end
        check("rst_mid_valid_seen", seen, 1);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_valid", mem_valid, 0);
        check("rst_mid_hold", hold, 0);
        check("rst_mid_busy", busy, 0);
        reset = 1'b0;
        ref_hold = 1'b0;
        mem_delay = 0;
        repeat (30) @(negedge clk);
        check("rst_mid_no_reply", tx_got.size(), 0);
        check("rst_mid_no_txn", got_addr.size(), 0);
        queue_cmd(8'h52, 32'h0000_0100, 32'h0);
        drain("after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
